// File: rtl/seg7_scroll_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scroll_mux
//  Purpose  : Time-multiplexed common-bus 7-segment display driver with an
//             internal writable message buffer, a NUM_DIGITS-wide window onto
//             it that can scroll at a programmable rate, and a glyph ROM
//             (hex digits plus a few letters/symbols).
//  Ports    :
//     clk              system clock
//     rst              asynchronous active-high reset
//     i_scroll_en      window advances while high
//     i_scroll_restart pulse: window offset back to 0 (beats scroll_en)
//     i_wr_en          write one message entry
//     i_wr_addr        message entry index
//     i_wr_data        glyph code (0..31)
//     o_segments       {g,f,e,d,c,b,a}, active high, registered
//     o_digit_en       one-hot digit enable, active high, registered
//     o_digit_idx      digit currently being scanned
//     o_wrap_pulse     one-clock pulse when the offset wraps to 0
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scroll_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int MSG_LEN    = 8,
   parameter int MUX_DIV    = 2,
   parameter int SCROLL_DIV = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_scroll_en,
   input  logic                          i_scroll_restart,
   input  logic                          i_wr_en,
   input  logic [$clog2(MSG_LEN)-1:0]    i_wr_addr,
   input  logic [4:0]                    i_wr_data,
   output logic [6:0]                    o_segments,
   output logic [NUM_DIGITS-1:0]         o_digit_en,
   output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx,
   output logic                          o_wrap_pulse
);

   localparam int c_AW = $clog2(MSG_LEN);
   localparam int c_DW = $clog2(NUM_DIGITS);
   localparam int c_MW = $clog2(MUX_DIV);
   localparam int c_SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   localparam logic [c_MW-1:0] c_MUX_LAST = c_MW'(MUX_DIV - 1);
   localparam logic [c_DW-1:0] c_DIG_LAST = c_DW'(NUM_DIGITS - 1);
   localparam logic [c_SW-1:0] c_SCR_LAST = c_SW'(SCROLL_DIV - 1);
   localparam logic [c_AW-1:0] c_OFF_LAST = c_AW'(MSG_LEN - 1);
   localparam logic [4:0]      c_BLANK    = 5'd16;

   logic [c_MW-1:0]       r_mux_cnt;
   logic [c_DW-1:0]       r_digit_idx;
   logic [c_SW-1:0]       r_scroll_cnt;
   logic [c_AW-1:0]       r_offset;
   logic                  r_wrap_pulse;
   logic [4:0]            r_msg [MSG_LEN];
   logic [6:0]            r_segments;
   logic [NUM_DIGITS-1:0] r_digit_en;

   logic                  w_mux_tick;
   logic                  w_scroll_tick;
   logic                  w_slot_first;
   logic [c_AW-1:0]       w_rd_addr;
   logic [4:0]            w_glyph_code;
   logic [6:0]            w_glyph_seg;
   logic [NUM_DIGITS-1:0] w_onehot;

   assign w_mux_tick    = (r_mux_cnt == c_MUX_LAST);
   assign w_scroll_tick = i_scroll_en && (r_scroll_cnt == c_SCR_LAST);
   // mux_cnt==0 marks the first cycle of a slot: the digit index has just
   // changed, so the enable is held off for one clock to avoid ghosting.
   assign w_slot_first  = (r_mux_cnt == '0);

   // ------------------------------------------------------------------
   // Digit scan: slot counter and digit index
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mux_cnt   <= '0;
         r_digit_idx <= '0;
      end else begin
         if (w_mux_tick) begin
            r_mux_cnt <= '0;
            if (r_digit_idx == c_DIG_LAST) begin
               r_digit_idx <= '0;
            end else begin
               r_digit_idx <= r_digit_idx + 1'b1;
            end
         end else begin
            r_mux_cnt <= r_mux_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Scroll: step counter, window offset and wrap pulse.
   // Offset wraps naturally because MSG_LEN is a power of two.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scroll_cnt <= '0;
         r_offset     <= '0;
         r_wrap_pulse <= 1'b0;
      end else begin
         r_wrap_pulse <= 1'b0;
         if (i_scroll_restart) begin
            r_scroll_cnt <= '0;
            r_offset     <= '0;
         end else if (w_scroll_tick) begin
            r_scroll_cnt <= '0;
            r_offset     <= r_offset + 1'b1;
            r_wrap_pulse <= (r_offset == c_OFF_LAST);
         end else if (i_scroll_en) begin
            r_scroll_cnt <= r_scroll_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Message buffer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            r_msg[i] <= c_BLANK;
         end
      end else if (i_wr_en) begin
         r_msg[i_wr_addr] <= i_wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Window read and glyph ROM
   // ------------------------------------------------------------------
   assign w_rd_addr    = r_offset + c_AW'(r_digit_idx);
   assign w_glyph_code = r_msg[w_rd_addr];
   assign w_onehot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_digit_idx;

   always_comb begin
      w_glyph_seg = 7'b0000000;
      case (w_glyph_code)
         5'd0:    w_glyph_seg = 7'b0111111;
         5'd1:    w_glyph_seg = 7'b0000110;
         5'd2:    w_glyph_seg = 7'b1011011;
         5'd3:    w_glyph_seg = 7'b1001111;
         5'd4:    w_glyph_seg = 7'b1100110;
         5'd5:    w_glyph_seg = 7'b1101101;
         5'd6:    w_glyph_seg = 7'b1111101;
         5'd7:    w_glyph_seg = 7'b0000111;
         5'd8:    w_glyph_seg = 7'b1111111;
         5'd9:    w_glyph_seg = 7'b1101111;
         5'd10:   w_glyph_seg = 7'b1110111;   // A
         5'd11:   w_glyph_seg = 7'b1111100;   // b
         5'd12:   w_glyph_seg = 7'b0111001;   // C
         5'd13:   w_glyph_seg = 7'b1011110;   // d
         5'd14:   w_glyph_seg = 7'b1111001;   // E
         5'd15:   w_glyph_seg = 7'b1110001;   // F
         5'd17:   w_glyph_seg = 7'b1110000;   // R
         5'd18:   w_glyph_seg = 7'b0111101;   // G
         5'd19:   w_glyph_seg = 7'b0111000;   // L
         5'd20:   w_glyph_seg = 7'b0110000;   // I
         5'd21:   w_glyph_seg = 7'b1000000;   // dash
         default: w_glyph_seg = 7'b0000000;   // 16 and 22..31: blank
      endcase
   end

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_segments <= '0;
         r_digit_en <= '0;
      end else begin
         r_segments <= w_glyph_seg;
         r_digit_en <= w_slot_first ? '0 : w_onehot;
      end
   end

   assign o_segments   = r_segments;
   assign o_digit_en   = r_digit_en;
   assign o_digit_idx  = r_digit_idx;
   assign o_wrap_pulse = r_wrap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scroll_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scroll_mux
//  Purpose  : Self-checking bench for seg7_scroll_mux (4 digits, 8 entries,
//             MUX_DIV=2, SCROLL_DIV=16). A time-based reference model is
//             compared against the DUT every cycle; directed checks pin the
//             model to hand-computed glyphs and enable patterns.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scroll_mux;

   localparam int ND = 4;
   localparam int ML = 8;
   localparam int MD = 2;
   localparam int SD = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_scroll_en = 1'b0;
   logic       i_scroll_restart = 1'b0;
   logic       i_wr_en = 1'b0;
   logic [2:0] i_wr_addr = '0;
   logic [4:0] i_wr_data = '0;
   logic [6:0] o_segments;
   logic [3:0] o_digit_en;
   logic [1:0] o_digit_idx;
   logic       o_wrap_pulse;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   seg7_scroll_mux #(.NUM_DIGITS(ND), .MSG_LEN(ML), .MUX_DIV(MD), .SCROLL_DIV(SD)) dut (
      .clk(clk), .rst(rst),
      .i_scroll_en(i_scroll_en), .i_scroll_restart(i_scroll_restart),
      .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .o_segments(o_segments), .o_digit_en(o_digit_en),
      .o_digit_idx(o_digit_idx), .o_wrap_pulse(o_wrap_pulse)
   );

   always #5 clk = ~clk;

   // Glyph table straight from the code list (g..a).
   logic [6:0] glyph_tab [32] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001,
      7'b0000000, 7'b1110000, 7'b0111101, 7'b0111000,
      7'b0110000, 7'b1000000, 7'b0000000, 7'b0000000,
      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

   // ---------------- reference model ----------------
   // Scan position derives from the number of clocks since reset release;
   // the scroll position from the number of enabled clocks since the last
   // restart.
   int         m_t;
   int         m_steps;
   int         m_msg [ML];
   logic [6:0] exp_seg;
   logic [3:0] exp_den;
   logic       exp_wrap;
   logic [1:0] exp_idx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = 0; m_steps = 0;
         for (int i = 0; i < ML; i++) m_msg[i] = 16;
         exp_seg = '0; exp_den = '0; exp_wrap = 1'b0; exp_idx = '0;
      end else begin
         int slot_pos, dig, off;
         slot_pos = m_t % MD;
         dig      = (m_t / MD) % ND;
         off      = (m_steps / SD) % ML;
         exp_seg  = glyph_tab[m_msg[(off + dig) % ML]];
         exp_den  = (slot_pos == 0) ? 4'b0000 : 4'(1 << dig);
         exp_wrap = 1'b0;
         if (i_scroll_restart) begin
            m_steps = 0;
         end else if (i_scroll_en) begin
            m_steps = m_steps + 1;
            if (m_steps % (SD * ML) == 0) exp_wrap = 1'b1;
         end
         if (i_wr_en) m_msg[i_wr_addr] = int'(i_wr_data);
         m_t     = m_t + 1;
         exp_idx = 2'((m_t / MD) % ND);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         check("model_seg",  32'(o_segments),   32'(exp_seg));
         check("model_den",  32'(o_digit_en),   32'(exp_den));
         check("model_wrap", 32'(o_wrap_pulse), 32'(exp_wrap));
         check("model_idx",  32'(o_digit_idx),  32'(exp_idx));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         cyc++;
      end
   endtask

   task automatic write(input int a, input int d);
      i_wr_en = 1'b1; i_wr_addr = 3'(a); i_wr_data = 5'(d);
      step(1);
      i_wr_en = 1'b0;
   endtask

   task automatic wait_digit(input int d, input string name);
      int budget = 4 * ND * MD;
      while (o_digit_en !== 4'(1 << d) && budget > 0) begin
         step(1);
         budget--;
      end
      check(name, 32'(budget > 0), 32'd1);
   endtask

   logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010,
                           4'b0000, 4'b0100, 4'b0000, 4'b1000};
   int cyc0;
   int wraps;
   int budget;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_seg",  32'(o_segments),   32'd0);
      check("rst_den",  32'(o_digit_en),   32'd0);
      check("rst_wrap", 32'(o_wrap_pulse), 32'd0);
      check("rst_idx",  32'(o_digit_idx),  32'd0);
      rst = 1'b0;

      // Enable sequence after release, blank message
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("den_seq%0d", i), 32'(o_digit_en), 32'(seq[i]));
         check($sformatf("blank_seg%0d", i), 32'(o_segments), 32'd0);
      end
      #2;

      // "ROGE" static
      write(0, 17); write(1, 0); write(2, 18); write(3, 14);
      step(1);
      wait_digit(0, "wait_d0"); check("roge_d0", 32'(o_segments), 32'b1110000);
      wait_digit(1, "wait_d1"); check("roge_d1", 32'(o_segments), 32'b0111111);
      wait_digit(2, "wait_d2"); check("roge_d2", 32'(o_segments), 32'b0111101);
      wait_digit(3, "wait_d3"); check("roge_d3", 32'(o_segments), 32'b1111001);

      // Scrolling
      write(4, 19); write(5, 20); write(6, 0); write(7, 16);
      i_scroll_en = 1'b1;
      cyc0 = cyc;
      step(17);
      wait_digit(0, "wait_s16");
      check("scroll16_d0", 32'(o_segments), 32'b0111111);
      step((cyc0 + 65) - cyc);
      wait_digit(0, "wait_s64");
      check("scroll64_d0", 32'(o_segments), 32'b0111000);
      wraps = 0;
      while (cyc < cyc0 + 131) begin
         step(1);
         if (o_wrap_pulse) wraps++;
      end
      check("wrap_once", 32'(wraps), 32'd1);
      wait_digit(0, "wait_wrap");
      check("wrap_d0", 32'(o_segments), 32'b1110000);

      // Restart coinciding with a scroll tick at offset 5
      step((cyc0 + 223) - cyc);
      i_scroll_restart = 1'b1;
      step(1);
      i_scroll_restart = 1'b0;
      i_scroll_en = 1'b0;
      check("restart_nowrap", 32'(o_wrap_pulse), 32'd0);
      step(1);
      check("restart_nowrap2", 32'(o_wrap_pulse), 32'd0);
      wait_digit(0, "wait_rs");
      check("restart_d0", 32'(o_segments), 32'b1110000);

      // Write to the digit being scanned
      budget = 20;
      while (!(o_digit_idx == 2'd1 && o_digit_en == 4'b0001) && budget > 0) begin
         step(1); budget--;
      end
      check("wait_idx1a", 32'(budget > 0), 32'd1);
      write(1, 21);
      check("wr_old_seg", 32'(o_segments), 32'b0111111);
      step(1);
      check("wr_dash_den", 32'(o_digit_en), 32'b0010);
      check("wr_dash_seg", 32'(o_segments), 32'b1000000);
      budget = 20;
      while (!(o_digit_idx == 2'd1 && o_digit_en == 4'b0001) && budget > 0) begin
         step(1); budget--;
      end
      check("wait_idx1b", 32'(budget > 0), 32'd1);
      write(1, 27);
      step(1);
      check("wr_27_den", 32'(o_digit_en), 32'b0010);
      check("wr_27_seg", 32'(o_segments), 32'b0000000);

      // Asynchronous reset mid-slot
      wait_digit(2, "wait_rst_d2");
      #1 rst = 1'b1;
      #1;
      check("async_seg", 32'(o_segments), 32'd0);
      check("async_den", 32'(o_digit_en), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      budget = 12;
      while (o_digit_en == 4'b0000 && budget > 0) begin
         step(1); budget--;
      end
      check("first_lit", 32'(o_digit_en), 32'b0001);

      step(4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/seg7_scroll_mux.md
Name: seg7_scroll_mux

Overview:
- Drives a multi-digit, time-multiplexed common-bus 7-segment display.
- Holds a writable message of glyph codes and shows a NUM_DIGITS-wide window of it.
- The window optionally scrolls at a programmable rate.
- Sits between the user-logic message source and the display pads; contains its own glyph ROM (hex digits plus letters).

Parameters:
- NUM_DIGITS, 4, number of physical digits multiplexed (>=2).
- MSG_LEN, 8, message buffer entries (>=NUM_DIGITS, power of 2).
- MUX_DIV, 2, clocks per digit slot (>=2).
- SCROLL_DIV, 16, clocks per scroll step (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- scroll_en  in  1  window advances while high.
- scroll_restart  in  1  pulse: window offset back to 0.
- wr_en  in  1  write message entry.
- wr_addr  in  $clog2(MSG_LEN)  entry index.
- wr_data  in  5  glyph code.
- segments  out  7  bit0=a(top) .. bit5=f(upper-left), bit6=g(middle); active high, registered.
- digit_en  out  NUM_DIGITS  one-hot digit enable, active high, registered.
- digit_idx  out  $clog2(NUM_DIGITS)  digit currently being scanned (internal counter).
- wrap_pulse  out  1  one-clock pulse when offset wraps MSG_LEN-1 -> 0.

Behaviour:
- Reset (async, rst=1): all message entries = 16 (blank); offset, digit_idx, mux_cnt and scroll_cnt = 0; segments=0, digit_en=0, wrap_pulse=0.
- Glyph ROM, code -> segments (g..a):
  - Hex digits: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
  - Letters/symbols: 16=blank 0000000, 17=R 1110000, 18=G 0111101, 19=L 0111000, 20=I 0110000, 21=dash 1000000.
  - 22-31 = blank.
- Mux counter:
  - mux_cnt counts 0..MUX_DIV-1 and wraps.
  - Mux tick = the cycle with mux_cnt==MUX_DIV-1; on that edge digit_idx increments mod NUM_DIGITS.
- Scroll counter:
  - While scroll_en=1, scroll_cnt counts 0..SCROLL_DIV-1.
  - At terminal count, offset increments mod MSG_LEN; if offset was MSG_LEN-1, wrap_pulse=1 for the next cycle.
  - While scroll_en=0, scroll_cnt and offset hold.
- scroll_restart:
  - Priority over the scroll tick and over scroll_en.
  - offset<=0, scroll_cnt<=0; no wrap_pulse.
- Displayed glyph for digit d: msg[(offset+d) mod MSG_LEN].
  - Digit 0 is the leftmost and shows the lowest message index.
- Output registration:
  - segments/digit_en are registered from current digit_idx/offset/msg, so they lag by one clock.
  - On the edge following a mux tick (first cycle of a new slot), digit_en <= 0 (anti-ghost gap) while segments load the new glyph.
  - On all other edges, digit_en <= one-hot(digit_idx).
  - Each digit is therefore lit MUX_DIV-1 of every MUX_DIV clocks.
- Writes:
  - Take effect on the clock edge; msg[wr_addr]<=wr_data.
  - A write to the entry currently displayed appears on segments at the next output update (one edge later).
  - Writes are independent of scroll and mux activity; no stall.
- Simultaneous events:
  - A scroll tick and a mux tick in the same cycle both apply.
  - The output register sees the old offset/idx that cycle and the new values on the next edge.
- Reset asserted mid-scan immediately forces outputs to 0 (async); scanning restarts at digit 0, offset 0 after release.

Test Plan (NUM_DIGITS=4, MSG_LEN=8, MUX_DIV=2, SCROLL_DIV=16):
- Reset, no writes, scroll_en=0 -> segments=0 always; digit_en sequence 0,0001,0,0010,0,0100,0,1000, repeating.
- Write msg[0..3]=17,0,18,14 ("ROGE"), scroll_en=0 -> when digit_en=0001 segments=1110000; 0010->0111111; 0100->0111101; 1000->1111001.
- Write msg[4..7]=19,20,0,16, scroll_en=1 -> after 16 clocks digit 0 shows O (0111111); after 64 clocks digit 0 shows L (0111000); after 128 clocks offset=0 again and wrap_pulse is high exactly one clock.
- scroll_restart pulse while offset=5 and a scroll tick coincides -> offset=0, no wrap_pulse, digit 0 shows msg[0].
- Write msg[1]=21 while digit 1 is being scanned -> segments=1000000 one edge later; code 27 written -> blank 0000000.
- Assert rst mid-slot with digit_en=0100 -> segments=0, digit_en=0 immediately without a clock; after release the first lit digit is 0001.
